// File: rtl/mtsp_inter_queue.sv
// Interbus queue pair: a read queue filled from external and drained by the interbus,
// and a write queue pushed by the interbus and drained to external. Define
// MTSP_INTER_QUEUE_OREG_EN to add a registered output stage on the read-queue head.
module mtsp_inter_queue #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  FLUSH,
  input  logic                  QW_WE,
  input  logic [255:0]          QW_DATA,
  input  logic                  QR_RE,
  output logic [255:0]          QR_DATA,
  output logic                  QR_VALID,
  input  logic [255:0]          EX_RDATA,
  input  logic                  EX_RVALID,
  output logic                  EX_RREADY,
  output logic [255:0]          EX_WDATA,
  output logic                  EX_WVALID,
  input  logic                  EX_WREADY,
  output logic [DEPTH_LOG2:0]   RQ_LEVEL,
  output logic [DEPTH_LOG2:0]   WQ_LEVEL,
  output logic                  WQ_OVERFLOW
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   ONE_LVL  = (DEPTH_LOG2+1)'(1'b1);
  localparam logic [DEPTH_LOG2-1:0] ONE_PTR  = DEPTH_LOG2'(1'b1);

  function automatic logic [DEPTH_LOG2:0] next_cnt(input logic [DEPTH_LOG2:0] cnt,
                                                   input logic push, input logic pop);
    logic [DEPTH_LOG2:0] res;
    case ({push, pop})
      2'b10:   res = cnt + ONE_LVL;
      2'b01:   res = cnt - ONE_LVL;
      default: res = cnt;
    endcase
    return res;
  endfunction

  // ---------------- write queue ----------------
  logic [255:0]          wq_mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wq_wptr_r;
  logic [DEPTH_LOG2-1:0] wq_rptr_r;
  logic [DEPTH_LOG2:0]   wq_cnt_r;
  logic                  wq_ovf_r;
  logic                  wq_full_s;
  logic                  wq_push_s;
  logic                  wq_pop_s;
  logic                  wq_drop_s;

  assign wq_full_s   = (wq_cnt_r == FULL_LVL);
  assign EX_WVALID   = (wq_cnt_r != '0);
  assign EX_WDATA    = EX_WVALID ? wq_mem_r[wq_rptr_r] : 256'b0;
  assign wq_pop_s    = EX_WVALID & EX_WREADY;
  // A full queue still accepts a push when its head leaves in the same cycle.
  assign wq_push_s   = QW_WE & (~wq_full_s | wq_pop_s);
  assign wq_drop_s   = QW_WE & wq_full_s & ~wq_pop_s;
  assign WQ_LEVEL    = wq_cnt_r;
  assign WQ_OVERFLOW = wq_ovf_r;

  always_ff @(posedge CLK) begin
    if (wq_push_s & ~FLUSH) begin
      wq_mem_r[wq_wptr_r] <= QW_DATA;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wq_wptr_r <= '0;
      wq_rptr_r <= '0;
      wq_cnt_r  <= '0;
      wq_ovf_r  <= 1'b0;
    end else if (FLUSH) begin
      wq_wptr_r <= '0;
      wq_rptr_r <= '0;
      wq_cnt_r  <= '0;
      wq_ovf_r  <= 1'b0;
    end else begin
      if (wq_push_s) begin
        wq_wptr_r <= wq_wptr_r + ONE_PTR;
      end
      if (wq_pop_s) begin
        wq_rptr_r <= wq_rptr_r + ONE_PTR;
      end
      wq_cnt_r <= next_cnt(wq_cnt_r, wq_push_s, wq_pop_s);
      if (wq_drop_s) begin
        wq_ovf_r <= 1'b1;
      end
    end
  end

  // ---------------- read queue ----------------
  logic [255:0]          rq_mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] rq_wptr_r;
  logic [DEPTH_LOG2-1:0] rq_rptr_r;
  logic [DEPTH_LOG2:0]   rq_cnt_r;
  logic [DEPTH_LOG2:0]   rq_level_s;
  logic [255:0]          rq_head_s;
  logic                  rq_full_s;
  logic                  rq_push_s;
  logic                  rq_rd_s;
  logic                  rq_nonempty_s;
  logic                  qr_pop_s;

  // Full implies a valid head, so QR_RE alone signals a pending pop.
  assign rq_full_s     = (rq_level_s == FULL_LVL);
  assign EX_RREADY     = ~rq_full_s | QR_RE;
  assign rq_push_s     = EX_RVALID & EX_RREADY;
  assign rq_head_s     = rq_mem_r[rq_rptr_r];
  assign rq_nonempty_s = (rq_cnt_r != '0);
  assign RQ_LEVEL      = rq_level_s;

`ifdef MTSP_INTER_QUEUE_OREG_EN
  logic         oreg_v_r;
  logic [255:0] oreg_data_r;

  // The RAM head moves into the output stage whenever that stage is free or leaving.
  assign qr_pop_s   = oreg_v_r & QR_RE;
  assign rq_rd_s    = rq_nonempty_s & (~oreg_v_r | qr_pop_s);
  assign rq_level_s = rq_cnt_r + (DEPTH_LOG2+1)'(oreg_v_r);
  assign QR_VALID   = oreg_v_r;
  assign QR_DATA    = oreg_data_r;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      oreg_v_r    <= 1'b0;
      oreg_data_r <= 256'b0;
    end else if (FLUSH) begin
      oreg_v_r    <= 1'b0;
      oreg_data_r <= 256'b0;
    end else if (rq_rd_s) begin
      oreg_v_r    <= 1'b1;
      oreg_data_r <= rq_head_s;
    end else if (qr_pop_s) begin
      oreg_v_r    <= 1'b0;
      oreg_data_r <= 256'b0;
    end else begin
      oreg_v_r    <= oreg_v_r;
      oreg_data_r <= oreg_data_r;
    end
  end
`else
  assign QR_VALID   = rq_nonempty_s;
  assign qr_pop_s   = QR_VALID & QR_RE;
  assign rq_rd_s    = qr_pop_s;
  assign rq_level_s = rq_cnt_r;
  assign QR_DATA    = QR_VALID ? rq_head_s : 256'b0;
`endif

  always_ff @(posedge CLK) begin
    if (rq_push_s & ~FLUSH) begin
      rq_mem_r[rq_wptr_r] <= EX_RDATA;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rq_wptr_r <= '0;
      rq_rptr_r <= '0;
      rq_cnt_r  <= '0;
    end else if (FLUSH) begin
      rq_wptr_r <= '0;
      rq_rptr_r <= '0;
      rq_cnt_r  <= '0;
    end else begin
      if (rq_push_s) begin
        rq_wptr_r <= rq_wptr_r + ONE_PTR;
      end
      if (rq_rd_s) begin
        rq_rptr_r <= rq_rptr_r + ONE_PTR;
      end
      rq_cnt_r <= next_cnt(rq_cnt_r, rq_push_s, rq_rd_s);
    end
  end

endmodule

// File: tb/tb_mtsp_inter_queue.sv
// Directed bench for mtsp_inter_queue (DEPTH_LOG2 = 4): a per-cycle vector table plus
// hand sequences for fill/drain, overflow, streaming, async reset and flush.
module tb_mtsp_inter_queue;

  logic         CLK = 1'b0;
  logic         nRST;
  logic         FLUSH;
  logic         QW_WE;
  logic [255:0] QW_DATA;
  logic         QR_RE;
  logic [255:0] QR_DATA;
  logic         QR_VALID;
  logic [255:0] EX_RDATA;
  logic         EX_RVALID;
  logic         EX_RREADY;
  logic [255:0] EX_WDATA;
  logic         EX_WVALID;
  logic         EX_WREADY;
  logic [4:0]   RQ_LEVEL;
  logic [4:0]   WQ_LEVEL;
  logic         WQ_OVERFLOW;

  int checks = 0;
  int errors = 0;

`ifdef MTSP_INTER_QUEUE_OREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  mtsp_inter_queue #(.DEPTH_LOG2(4)) dut (
    .CLK(CLK), .nRST(nRST), .FLUSH(FLUSH), .QW_WE(QW_WE), .QW_DATA(QW_DATA),
    .QR_RE(QR_RE), .QR_DATA(QR_DATA), .QR_VALID(QR_VALID), .EX_RDATA(EX_RDATA),
    .EX_RVALID(EX_RVALID), .EX_RREADY(EX_RREADY), .EX_WDATA(EX_WDATA),
    .EX_WVALID(EX_WVALID), .EX_WREADY(EX_WREADY), .RQ_LEVEL(RQ_LEVEL),
    .WQ_LEVEL(WQ_LEVEL), .WQ_OVERFLOW(WQ_OVERFLOW)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic         flush;
    logic         qw_we;
    logic [255:0] qw_data;
    logic         ex_wready;
    logic         qr_re;
    logic         ex_rvalid;
    logic [255:0] ex_rdata;
    logic         exp_rready;
    logic [4:0]   exp_rq_level;
    logic [4:0]   exp_wq_level;
    logic         exp_wvalid;
    logic [255:0] exp_wdata;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs [10];

  function automatic vec_t mk(input logic fl, input logic we, input logic [255:0] wd,
                              input logic wr, input logic re, input logic rv,
                              input logic [255:0] rd, input logic e_rr, input logic [4:0] e_rq,
                              input logic [4:0] e_wq, input logic e_wv,
                              input logic [255:0] e_wd, input logic e_ovf);
    vec_t v;
    v.flush = fl; v.qw_we = we; v.qw_data = wd; v.ex_wready = wr; v.qr_re = re;
    v.ex_rvalid = rv; v.ex_rdata = rd; v.exp_rready = e_rr; v.exp_rq_level = e_rq;
    v.exp_wq_level = e_wq; v.exp_wvalid = e_wv; v.exp_wdata = e_wd; v.exp_ovf = e_ovf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    FLUSH = 1'b0; QW_WE = 1'b0; QW_DATA = 256'b0; QR_RE = 1'b0;
    EX_RVALID = 1'b0; EX_RDATA = 256'b0; EX_WREADY = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int npops;
    int exp_d;
    nRST = 1'b0;
    idle();
    vecs[0] = mk(1'b0, 1'b1, 256'h11, 1'b0, 1'b0, 1'b0, 256'h0,  1'b1, 5'd0, 5'd1, 1'b1, 256'h11, 1'b0);
    vecs[1] = mk(1'b0, 1'b1, 256'h22, 1'b1, 1'b0, 1'b0, 256'h0,  1'b1, 5'd0, 5'd1, 1'b1, 256'h22, 1'b0);
    vecs[2] = mk(1'b0, 1'b0, 256'h0,  1'b0, 1'b0, 1'b0, 256'h0,  1'b1, 5'd0, 5'd1, 1'b1, 256'h22, 1'b0);
    vecs[3] = mk(1'b0, 1'b1, 256'h33, 1'b0, 1'b0, 1'b0, 256'h0,  1'b1, 5'd0, 5'd2, 1'b1, 256'h22, 1'b0);
    vecs[4] = mk(1'b0, 1'b0, 256'h0,  1'b1, 1'b0, 1'b0, 256'h0,  1'b1, 5'd0, 5'd1, 1'b1, 256'h33, 1'b0);
    vecs[5] = mk(1'b0, 1'b0, 256'h0,  1'b1, 1'b0, 1'b0, 256'h0,  1'b1, 5'd0, 5'd0, 1'b0, 256'h0,  1'b0);
    vecs[6] = mk(1'b0, 1'b0, 256'h0,  1'b1, 1'b0, 1'b0, 256'h0,  1'b1, 5'd0, 5'd0, 1'b0, 256'h0,  1'b0);
    vecs[7] = mk(1'b0, 1'b0, 256'h0,  1'b0, 1'b0, 1'b1, 256'h55, 1'b1, 5'd1, 5'd0, 1'b0, 256'h0,  1'b0);
    vecs[8] = mk(1'b0, 1'b1, 256'h44, 1'b0, 1'b0, 1'b1, 256'h66, 1'b1, 5'd2, 5'd1, 1'b1, 256'h44, 1'b0);
    vecs[9] = mk(1'b1, 1'b1, 256'h77, 1'b1, 1'b1, 1'b1, 256'h88, 1'b1, 5'd0, 5'd0, 1'b0, 256'h0,  1'b0);

    // Reset values, sampled while reset is held and right after release.
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_qr_valid", QR_VALID, 1'b0);
    chk("rst_ex_wvalid", EX_WVALID, 1'b0);
    nRST = 1'b1;
    #1;
    chk("rst_rq_level", RQ_LEVEL, 5'd0);
    chk("rst_wq_level", WQ_LEVEL, 5'd0);
    chk("rst_ovf", WQ_OVERFLOW, 1'b0);
    chk("rst_qr_data", QR_DATA, 256'h0);
    chk("rst_ex_wdata", EX_WDATA, 256'h0);
    chk("rst_ex_rready", EX_RREADY, 1'b1);
    tick();

    for (int i = 0; i < 10; i++) begin
      FLUSH = vecs[i].flush; QW_WE = vecs[i].qw_we; QW_DATA = vecs[i].qw_data;
      EX_WREADY = vecs[i].ex_wready; QR_RE = vecs[i].qr_re;
      EX_RVALID = vecs[i].ex_rvalid; EX_RDATA = vecs[i].ex_rdata;
      #1;
      chk($sformatf("v%0d_ex_rready", i), EX_RREADY, vecs[i].exp_rready);
      tick();
      chk($sformatf("v%0d_rq_level", i), RQ_LEVEL, vecs[i].exp_rq_level);
      chk($sformatf("v%0d_wq_level", i), WQ_LEVEL, vecs[i].exp_wq_level);
      chk($sformatf("v%0d_ex_wvalid", i), EX_WVALID, vecs[i].exp_wvalid);
      chk($sformatf("v%0d_ex_wdata", i), EX_WDATA, vecs[i].exp_wdata);
      chk($sformatf("v%0d_ovf", i), WQ_OVERFLOW, vecs[i].exp_ovf);
    end
    idle();
    tick();

    // Read queue: fill to 16, push+pop while full, then drain in order.
    for (int i = 1; i <= 16; i++) begin
      EX_RVALID = 1'b1; EX_RDATA = 256'(i);
      tick();
    end
    EX_RVALID = 1'b0;
    #1;
    chk("rq_full_level", RQ_LEVEL, 5'd16);
    chk("rq_full_rready", EX_RREADY, 1'b0);
    QR_RE = 1'b1; EX_RVALID = 1'b1; EX_RDATA = 256'h99;
    #1;
    chk("rq_full_rready_pop", EX_RREADY, 1'b1);
    chk("rq_pop_1_valid", QR_VALID, 1'b1);
    chk("rq_pop_1_data", QR_DATA, 256'h1);
    tick();
    EX_RVALID = 1'b0;
    chk("rq_full_pushpop_level", RQ_LEVEL, 5'd16);
    for (int k = 2; k <= 17; k++) begin
      #1;
      chk($sformatf("rq_pop_%0d_valid", k), QR_VALID, 1'b1);
      chk($sformatf("rq_pop_%0d_data", k), QR_DATA, (k <= 16) ? 256'(k) : 256'h99);
      tick();
    end
    QR_RE = 1'b0;
    chk("rq_drained_level", RQ_LEVEL, 5'd0);
    chk("rq_drained_valid", QR_VALID, 1'b0);

    // Write queue: full push+pop keeps level, 0xAA emerges 16th.
    for (int i = 1; i <= 16; i++) begin
      QW_WE = 1'b1; QW_DATA = 256'(i);
      tick();
    end
    QW_WE = 1'b0;
    chk("wq_full_level", WQ_LEVEL, 5'd16);
    chk("wq_full_head", EX_WDATA, 256'h1);
    QW_WE = 1'b1; QW_DATA = 256'hAA; EX_WREADY = 1'b1;
    tick();
    QW_WE = 1'b0;
    chk("wq_pushpop_level", WQ_LEVEL, 5'd16);
    chk("wq_pushpop_ovf", WQ_OVERFLOW, 1'b0);
    for (int k = 2; k <= 17; k++) begin
      chk($sformatf("wq_drain_%0d", k), EX_WDATA, (k <= 16) ? 256'(k) : 256'hAA);
      tick();
    end
    EX_WREADY = 1'b0;
    chk("wq_drained_level", WQ_LEVEL, 5'd0);
    chk("wq_drained_valid", EX_WVALID, 1'b0);

    // Write queue overflow: dropped push, sticky flag, cleared by FLUSH.
    for (int i = 1; i <= 16; i++) begin
      QW_WE = 1'b1; QW_DATA = 256'(i + 8'h40);
      tick();
    end
    QW_DATA = 256'hAA;
    tick();
    QW_WE = 1'b0;
    chk("ovf_level", WQ_LEVEL, 5'd16);
    chk("ovf_flag", WQ_OVERFLOW, 1'b1);
    chk("ovf_head", EX_WDATA, 256'h41);
    tick();
    chk("ovf_sticky", WQ_OVERFLOW, 1'b1);
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    chk("flush_wq_level", WQ_LEVEL, 5'd0);
    chk("flush_ovf", WQ_OVERFLOW, 1'b0);
    chk("flush_wvalid", EX_WVALID, 1'b0);

    // Streaming: 100 consecutive pops with constant read level.
    npops = 0;
    exp_d = 1;
    for (int c = 0; c < 100 + LAT; c++) begin
      EX_RVALID = 1'b1; EX_RDATA = 256'(c + 1); QR_RE = 1'b1;
      #1;
      if (QR_VALID) begin
        chk($sformatf("stream_data_%0d", exp_d), QR_DATA, 256'(exp_d));
        exp_d++;
        npops++;
      end
      tick();
      if (c >= LAT - 1) begin
        chk($sformatf("stream_level_%0d", c), RQ_LEVEL, 5'(LAT));
      end
    end
    chk("stream_pop_count", 256'(npops), 256'd100);
    idle();
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;

    // Asynchronous reset with RQ_LEVEL=5, WQ_LEVEL=7.
    for (int i = 0; i < 7; i++) begin
      QW_WE = 1'b1; QW_DATA = 256'(i + 8'h70);
      EX_RVALID = (i < 5); EX_RDATA = 256'(i + 8'h50);
      tick();
    end
    idle();
    #1;
    chk("pre_rst_rq_level", RQ_LEVEL, 5'd5);
    chk("pre_rst_wq_level", WQ_LEVEL, 5'd7);
    #2;
    nRST = 1'b0;
    #1;
    chk("arst_rq_level", RQ_LEVEL, 5'd0);
    chk("arst_wq_level", WQ_LEVEL, 5'd0);
    chk("arst_qr_valid", QR_VALID, 1'b0);
    chk("arst_ex_wvalid", EX_WVALID, 1'b0);
    chk("arst_qr_data", QR_DATA, 256'h0);
    chk("arst_ex_wdata", EX_WDATA, 256'h0);
    #1;
    nRST = 1'b1;
    #1;
    chk("arst_rready", EX_RREADY, 1'b1);
    tick();

    // FLUSH wins over simultaneous push and pop on both queues.
    for (int i = 0; i < 2; i++) begin
      QW_WE = 1'b1; QW_DATA = 256'(i + 8'hC0);
      EX_RVALID = 1'b1; EX_RDATA = 256'(i + 8'hD0);
      tick();
    end
    FLUSH = 1'b1; QW_WE = 1'b1; QW_DATA = 256'hE0; EX_RVALID = 1'b1; EX_RDATA = 256'hE1;
    QR_RE = 1'b1; EX_WREADY = 1'b1;
    tick();
    idle();
    chk("fl_rq_level", RQ_LEVEL, 5'd0);
    chk("fl_wq_level", WQ_LEVEL, 5'd0);
    chk("fl_qr_valid", QR_VALID, 1'b0);
    chk("fl_ex_wvalid", EX_WVALID, 1'b0);
    tick();
    chk("fl_after_rq_level", RQ_LEVEL, 5'd0);
    chk("fl_after_wq_level", WQ_LEVEL, 5'd0);
    chk("fl_after_qr_data", QR_DATA, 256'h0);
    chk("fl_after_ex_wdata", EX_WDATA, 256'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mtsp_inter_queue.md
MTSP_INTER_QUEUE -- requirements
Module: mtsp_inter_queue

Interface
REQ-001: Parameter DEPTH_LOG2, default 4, SHALL set each queue to 2^DEPTH_LOG2 entries of 256 bits.
REQ-002: CLK  input  1  main clock; all state SHALL be updated on its rising edge.
REQ-003: nRST  input  1  reset; one clock, asynchronous, active-low (polarity and synchronicity fixed).
REQ-004: FLUSH  input  1  synchronous clear of both queues and the overflow flag.
REQ-005: QW_WE  input  1  write-queue push strobe from the interbus; carries no backpressure.
REQ-006: QW_DATA  input  256  write-queue push data.
REQ-007: QR_RE  input  1  read-queue consumer ready.
REQ-008: QR_DATA  output  256  read-queue head data.
REQ-009: QR_VALID  output  1  read-queue head valid.
REQ-010: EX_RDATA / EX_RVALID  input  256 / 1  external fill data and valid into the read queue.
REQ-011: EX_RREADY  output  1  read queue can accept a fill.
REQ-012: EX_WDATA / EX_WVALID  output  256 / 1  write-queue head data and valid toward external.
REQ-013: EX_WREADY  input  1  external drain ready.
REQ-014: RQ_LEVEL / WQ_LEVEL  output  DEPTH_LOG2+1  occupancy of the read queue and the write queue.
REQ-015: WQ_OVERFLOW  output  1  sticky flag: a QW_WE push was dropped.

Function
REQ-016: Read-queue push SHALL occur when EX_RVALID&EX_RREADY; pop SHALL occur when QR_VALID&QR_RE.
REQ-017: Write-queue push SHALL occur when QW_WE and the write queue is not full; pop SHALL occur when EX_WVALID&EX_WREADY.
REQ-018: Both queues SHALL be show-ahead: head data is stable and presented while valid, and changes only on pop.
REQ-019: Pointers SHALL be DEPTH_LOG2 bits and wrap modulo depth; level SHALL be a DEPTH_LOG2+1-bit counter; full = (level == 2^DEPTH_LOG2); empty = (level == 0).
REQ-020: A simultaneous push and pop on a non-empty queue SHALL leave level unchanged, and both operations SHALL complete.
REQ-021: A simultaneous push and pop on a full queue SHALL be permitted for both queues.
REQ-022: EX_RREADY SHALL equal ~full(read queue), or pop-pending when full; it SHALL be combinational from level and QR_RE.
REQ-023: QW_WE on a full write queue without a same-cycle pop SHALL drop the data, leave level unchanged, and set WQ_OVERFLOW on the next edge.
REQ-024: WQ_OVERFLOW SHALL hold until FLUSH or reset.
REQ-025: EX_WVALID SHALL equal ~empty(write queue); EX_WDATA SHALL be the write-queue head.
REQ-026: Write-queue latency SHALL be 1 cycle: a push at edge N makes EX_WVALID high after edge N.
REQ-027: FLUSH SHALL take priority over push and pop in the same cycle.
REQ-028: After FLUSH, levels and flags SHALL be 0 on the next edge; data RAM contents are don't-care.
REQ-029: Throughput SHALL be one push and one pop per cycle per queue sustained.

Reset
REQ-030: On nRST low: pointers and levels SHALL be 0, and QR_VALID, EX_WVALID and WQ_OVERFLOW SHALL be 0.
REQ-031: On nRST low: QR_DATA and EX_WDATA SHALL be 256'b0 and EX_RREADY SHALL be 1 after release.
REQ-032: Reset asserted mid-transfer SHALL discard all queued entries without a partial pop.

Configuration
REQ-033: Macro MTSP_INTER_QUEUE_OREG_EN defined SHALL insert a registered output stage on the read-queue head.
REQ-034: With MTSP_INTER_QUEUE_OREG_EN defined, QR_DATA/QR_VALID SHALL come from flops, EX_RVALID-to-QR_VALID latency SHALL be 2 cycles, and full throughput SHALL be kept.
REQ-035: With MTSP_INTER_QUEUE_OREG_EN defined, RQ_LEVEL SHALL include the output-stage entry.
REQ-036: Without MTSP_INTER_QUEUE_OREG_EN, QR_DATA SHALL be driven from the array at the read pointer, and latency SHALL be 1 cycle.

Verification
REQ-037: Reset, then push 16 read fills 0x1..0x10 with QR_RE=0 -> RQ_LEVEL=16, EX_RREADY=0; then QR_RE=1 -> 16 pops in order 0x1..0x10, one per cycle.
REQ-038: Write queue full (16), QW_WE with 0xAA and EX_WREADY=0 -> WQ_LEVEL stays 16, WQ_OVERFLOW=1; after FLUSH -> WQ_LEVEL=0, WQ_OVERFLOW=0.
REQ-039: Write queue full, QW_WE and EX_WREADY in the same cycle -> level stays 16, no overflow, 0xAA emerges 16th.
REQ-040: Continuous EX_RVALID and QR_RE=1 for 100 cycles -> 100 consecutive matching pops, RQ_LEVEL constant (1, or 2 with OREG_EN).
REQ-041: Pulse nRST low while RQ_LEVEL=5 and WQ_LEVEL=7 -> all levels 0 and QR_VALID=EX_WVALID=0 immediately (asynchronous).
REQ-042: FLUSH asserted with a simultaneous push and pop on both queues -> both levels 0 on the next edge, and no data emitted.
